// File: rtl/scarv_soc_memif_arb.sv
// -----------------------------------------------------------------------------
// scarv_soc_memif_arb
//
// Two-requester arbiter in front of the single external memory/peripheral
// target. Requester 0 is the CPU core complex, requester 1 a second master
// (debug or DMA). One transaction is outstanding at a time; ownership is
// decided round-robin in IDLE, the request is forwarded from a register-driven
// state (no combinational req path), and the response path is combinational
// so it adds no latency. A response watchdog returns an error to the owner
// if the target stalls, then silently drains the late response.
//
// Parameters:
//   TIMEOUT  cycles allowed from request acceptance to response (0 = off)
//   CW       watchdog counter width, 2^CW > TIMEOUT
//
// Ports:
//   f_clk, g_resetn                  clock, asynchronous active-low reset
//   mN_req/wen/strb/addr/wdata       requester N request side (inputs)
//   mN_gnt                           requester N request accepted
//   mN_recv/error/rdata              requester N response side (outputs)
//   mN_ack                           requester N accepts the response
//   s_req/wen/strb/addr/wdata        request to the target
//   s_gnt                            target accepts the request
//   s_recv/error/rdata               target response
//   s_ack                            arbiter accepts the target response
//   timeout_seen                     sticky: a watchdog expiry has occurred
// -----------------------------------------------------------------------------
module scarv_soc_memif_arb #(
    parameter int TIMEOUT = 1024,
    parameter int CW      = 11
) (
    input  logic        f_clk,
    input  logic        g_resetn,

    input  logic        m0_req,
    input  logic        m0_wen,
    input  logic [3:0]  m0_strb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_recv,
    input  logic        m0_ack,
    output logic        m0_error,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_wen,
    input  logic [3:0]  m1_strb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_recv,
    input  logic        m1_ack,
    output logic        m1_error,
    output logic [31:0] m1_rdata,

    output logic        s_req,
    output logic        s_wen,
    output logic [3:0]  s_strb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_gnt,
    input  logic        s_recv,
    input  logic        s_error,
    input  logic [31:0] s_rdata,
    output logic        s_ack,

    output logic        timeout_seen
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_RSP   = 3'd2;
    localparam logic [2:0] ST_ERR   = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    localparam logic [CW-1:0] LP_TMO = CW'(TIMEOUT);

    logic [2:0]    r_state;
    logic          r_owner;
    logic          r_last;
    logic [CW-1:0] r_cnt;
    logic          r_tseen;

    logic [2:0]    w_state_nxt;
    logic          w_owner_nxt;
    logic          w_last_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_tseen_nxt;

    logic          w_pick;
    logic          w_own_ack;
    logic          w_in_req;
    logic          w_in_rsp;
    logic          w_in_err;
    logic          w_in_drain;

    assign w_in_req   = (r_state == ST_REQ);
    assign w_in_rsp   = (r_state == ST_RSP);
    assign w_in_err   = (r_state == ST_ERR);
    assign w_in_drain = (r_state == ST_DRAIN);

    // On contention the requester that did not win last time gets the bus;
    // with a single requester that requester wins outright.
    assign w_pick    = (m0_req && m1_req) ? ~r_last : m1_req;
    assign w_own_ack = r_owner ? m1_ack : m0_ack;

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_tseen_nxt = r_tseen;
        case (r_state)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    w_owner_nxt = w_pick;
                    w_last_nxt  = w_pick;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (s_gnt) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_RSP;
                end
            end
            ST_RSP: begin
                if (s_recv) begin
                    // A pending response always beats the watchdog; the
                    // counter is frozen while the owner backpressures it.
                    if (w_own_ack) begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (TIMEOUT != 0) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                    if (r_cnt + CW'(1) == LP_TMO) begin
                        w_tseen_nxt = 1'b1;
                        w_state_nxt = ST_ERR;
                    end
                end
            end
            ST_ERR: begin
                // Expiry only happens in a cycle without s_recv, so the
                // target's response is still owed and must be drained.
                if (w_own_ack) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (s_recv) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge f_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= '0;
            r_tseen <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tseen <= w_tseen_nxt;
        end
    end

    // Target request side: driven only from REQ, muxed from the owner.
    assign s_req   = w_in_req;
    assign s_wen   = w_in_req & (r_owner ? m1_wen : m0_wen);
    assign s_strb  = w_in_req ? (r_owner ? m1_strb  : m0_strb)  : 4'h0;
    assign s_addr  = w_in_req ? (r_owner ? m1_addr  : m0_addr)  : 32'h0;
    assign s_wdata = w_in_req ? (r_owner ? m1_wdata : m0_wdata) : 32'h0;

    assign m0_gnt  = w_in_req & ~r_owner & s_gnt;
    assign m1_gnt  = w_in_req &  r_owner & s_gnt;

    // Response side: pass-through in RSP, synthesized error in ERR.
    assign m0_recv  = ~r_owner & ((w_in_rsp & s_recv) | w_in_err);
    assign m1_recv  =  r_owner & ((w_in_rsp & s_recv) | w_in_err);
    assign m0_error = ~r_owner & ((w_in_rsp & s_recv & s_error) | w_in_err);
    assign m1_error =  r_owner & ((w_in_rsp & s_recv & s_error) | w_in_err);
    assign m0_rdata = (~r_owner & w_in_rsp & s_recv) ? s_rdata : 32'h0;
    assign m1_rdata = ( r_owner & w_in_rsp & s_recv) ? s_rdata : 32'h0;

    assign s_ack        = (w_in_rsp & w_own_ack) | w_in_drain;
    assign timeout_seen = r_tseen;

endmodule

// File: tb/tb_scarv_soc_memif_arb.sv
module tb_scarv_soc_memif_arb;

    logic        f_clk = 1'b0;
    logic        g_resetn;
    logic        m0_req, m0_wen, m0_ack;
    logic [3:0]  m0_strb;
    logic [31:0] m0_addr, m0_wdata;
    logic        m0_gnt, m0_recv, m0_error;
    logic [31:0] m0_rdata;
    logic        m1_req, m1_wen, m1_ack;
    logic [3:0]  m1_strb;
    logic [31:0] m1_addr, m1_wdata;
    logic        m1_gnt, m1_recv, m1_error;
    logic [31:0] m1_rdata;
    logic        s_req, s_wen, s_ack;
    logic [3:0]  s_strb;
    logic [31:0] s_addr, s_wdata;
    logic        s_gnt, s_recv, s_error;
    logic [31:0] s_rdata;
    logic        timeout_seen;

    int n_tests = 0;
    int n_fail  = 0;

    logic [13:0] w_ctl;
    logic [2:0]  w_m1ctl;
    assign w_ctl = {m0_gnt, m0_recv, m0_error, m1_gnt, m1_recv, m1_error,
                    s_req, s_wen, s_strb, s_ack, timeout_seen};
    assign w_m1ctl = {m1_gnt, m1_recv, m1_error};

    scarv_soc_memif_arb #(.TIMEOUT(8), .CW(4)) dut (
        .f_clk(f_clk), .g_resetn(g_resetn),
        .m0_req(m0_req), .m0_wen(m0_wen), .m0_strb(m0_strb),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
        .m0_recv(m0_recv), .m0_ack(m0_ack), .m0_error(m0_error),
        .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wen(m1_wen), .m1_strb(m1_strb),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
        .m1_recv(m1_recv), .m1_ack(m1_ack), .m1_error(m1_error),
        .m1_rdata(m1_rdata),
        .s_req(s_req), .s_wen(s_wen), .s_strb(s_strb), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_gnt(s_gnt), .s_recv(s_recv),
        .s_error(s_error), .s_rdata(s_rdata), .s_ack(s_ack),
        .timeout_seen(timeout_seen)
    );

    always #5 f_clk = ~f_clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge f_clk);
        #1;
    endtask

    initial begin
        g_resetn = 1'b0;
        m0_req = 0; m0_wen = 0; m0_ack = 0; m0_strb = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_wen = 0; m1_ack = 0; m1_strb = 0; m1_addr = 0; m1_wdata = 0;
        s_gnt = 0; s_recv = 0; s_error = 0; s_rdata = 0;
        #1;
        check("rst_ctl", 32'(w_ctl), 32'h0);
        check("rst_addr", s_addr, 32'h0);
        check("rst_wdata", s_wdata, 32'h0);
        check("rst_rdata0", m0_rdata, 32'h0);
        check("rst_rdata1", m1_rdata, 32'h0);
        tick();
        g_resetn = 1'b1;

        // ---- contention: owners m0, m1, m0, m1 ----
        m0_addr = 32'h100; m0_strb = 4'hF; m1_addr = 32'h200; m1_strb = 4'hF;
        m0_ack = 1; m1_ack = 1;
        m0_req = 1; m1_req = 1;
        #1;
        check("ct_no_comb_req", 32'(s_req), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ct_sreq", 32'(s_req), 32'h1);
            check("ct_addr", s_addr, (i % 2) ? 32'h200 : 32'h100);
            s_gnt = 1; #1;
            check("ct_gnt0", 32'(m0_gnt), (i % 2) ? 32'h0 : 32'h1);
            check("ct_gnt1", 32'(m1_gnt), (i % 2) ? 32'h1 : 32'h0);
            tick();
            s_gnt = 0; s_recv = 1; s_rdata = 32'h1111_0000 + 32'(i); #1;
            check("ct_recv0", 32'(m0_recv), (i % 2) ? 32'h0 : 32'h1);
            check("ct_recv1", 32'(m1_recv), (i % 2) ? 32'h1 : 32'h0);
            check("ct_rdata", (i % 2) ? m1_rdata : m0_rdata, 32'h1111_0000 + 32'(i));
            check("ct_sack", 32'(s_ack), 32'h1);
            tick();
            s_recv = 0;
            if (i == 3) begin
                m0_req = 0; m1_req = 0;
            end
            #1;
            check("ct_idle_gap", 32'(s_req), 32'h0);
        end
        m0_ack = 0; m1_ack = 0;

        // ---- single read by m0 ----
        m0_addr = 32'h1000_0004; m0_wen = 0; m0_strb = 4'hF; m0_req = 1; #1;
        check("rd_no_comb_req", 32'(s_req), 32'h0);
        tick();
        check("rd_sreq", 32'(s_req), 32'h1);
        check("rd_addr", s_addr, 32'h1000_0004);
        check("rd_wen", 32'(s_wen), 32'h0);
        check("rd_gnt_early", 32'(m0_gnt), 32'h0);
        tick();
        s_gnt = 1; #1;
        check("rd_gnt", 32'(m0_gnt), 32'h1);
        check("rd_m1_ctl", 32'(w_m1ctl), 32'h0);
        tick();
        s_gnt = 0; m0_req = 0; #1;
        check("rd_sreq_off", 32'(s_req), 32'h0);
        check("rd_recv_wait", 32'(m0_recv), 32'h0);
        tick(); tick();
        s_recv = 1; s_rdata = 32'hCAFE_F00D; m0_ack = 1; #1;
        check("rd_recv", 32'(m0_recv), 32'h1);
        check("rd_rdata", m0_rdata, 32'hCAFE_F00D);
        check("rd_sack", 32'(s_ack), 32'h1);
        check("rd_m1_ctl2", 32'(w_m1ctl), 32'h0);
        check("rd_m1_rdata", m1_rdata, 32'h0);
        tick();
        s_recv = 0; m0_ack = 0; #1;
        check("rd_done_recv", 32'(m0_recv), 32'h0);
        check("rd_done_rdata", m0_rdata, 32'h0);

        // ---- write by m1, error pass-through ----
        m1_addr = 32'h1000_1008; m1_wdata = 32'hA5A5_A5A5; m1_strb = 4'b0011;
        m1_wen = 1; m1_req = 1;
        tick();
        check("wr_wen", 32'(s_wen), 32'h1);
        check("wr_strb", 32'(s_strb), 32'h3);
        check("wr_addr", s_addr, 32'h1000_1008);
        check("wr_wdata", s_wdata, 32'hA5A5_A5A5);
        s_gnt = 1; #1;
        check("wr_gnt1", 32'(m1_gnt), 32'h1);
        check("wr_gnt0", 32'(m0_gnt), 32'h0);
        tick();
        s_gnt = 0; m1_req = 0; m1_wen = 0; #1;
        check("wr_recv_wait", 32'(m1_recv), 32'h0);
        s_recv = 1; s_error = 1; m1_ack = 1; #1;
        check("wr_recv", 32'(m1_recv), 32'h1);
        check("wr_error", 32'(m1_error), 32'h1);
        check("wr_tseen", 32'(timeout_seen), 32'h0);
        tick();
        s_recv = 0; s_error = 0; m1_ack = 0;

        // ---- backpressure on m0 ----
        m0_addr = 32'h40; m0_req = 1;
        tick();
        s_gnt = 1;
        tick();
        s_gnt = 0; m0_req = 0; s_recv = 1; s_rdata = 32'h5;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_sack_low", 32'(s_ack), 32'h0);
            check("bp_recv", 32'(m0_recv), 32'h1);
            tick();
        end
        m0_ack = 1; #1;
        check("bp_sack", 32'(s_ack), 32'h1);
        check("bp_rdata", m0_rdata, 32'h5);
        tick();
        check("bp_done", 32'(m0_recv), 32'h0);
        s_recv = 0; m0_ack = 0;

        // ---- watchdog expiry, drain, then m1 ----
        m0_addr = 32'h80; m0_req = 1;
        tick();
        s_gnt = 1;
        tick();
        s_gnt = 0; m0_req = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("to_wait_recv", 32'(m0_recv), 32'h0);
            check("to_wait_tseen", 32'(timeout_seen), 32'h0);
            tick();
        end
        check("to_recv", 32'(m0_recv), 32'h1);
        check("to_error", 32'(m0_error), 32'h1);
        check("to_rdata", m0_rdata, 32'h0);
        check("to_tseen", 32'(timeout_seen), 32'h1);
        check("to_sack", 32'(s_ack), 32'h0);
        m0_ack = 1;
        tick();
        m0_ack = 0; #1;
        check("dr_recv", 32'(m0_recv), 32'h0);
        check("dr_sack", 32'(s_ack), 32'h1);
        repeat (20) tick();
        m1_addr = 32'h300; m1_wen = 0; m1_strb = 4'hF; m1_req = 1;
        s_recv = 1; s_rdata = 32'hDEAD_BEEF; #1;
        check("dr_late_sack", 32'(s_ack), 32'h1);
        check("dr_late_recv0", 32'(m0_recv), 32'h0);
        check("dr_late_m1", 32'(w_m1ctl), 32'h0);
        tick();
        s_recv = 0; #1;
        check("dr_idle", 32'(s_req), 32'h0);
        tick();
        check("m1_sreq", 32'(s_req), 32'h1);
        check("m1_addr", s_addr, 32'h300);
        s_gnt = 1; #1;
        check("m1_gnt", 32'(m1_gnt), 32'h1);
        tick();
        s_gnt = 0; m1_req = 0; s_recv = 1; s_rdata = 32'h7; m1_ack = 1; #1;
        check("m1_recv", 32'(m1_recv), 32'h1);
        check("m1_error", 32'(m1_error), 32'h0);
        check("m1_rdata", m1_rdata, 32'h7);
        tick();
        s_recv = 0; m1_ack = 0;
        check("m1_tseen", 32'(timeout_seen), 32'h1);

        // ---- reset mid-RSP; last was m1, m0 made owner, then reset ----
        m0_addr = 32'h500; m0_req = 1;
        tick();
        s_gnt = 1;
        tick();
        s_gnt = 0; m0_req = 0;
        tick();
        g_resetn = 0; s_recv = 1; #1;
        check("rr_ctl", 32'(w_ctl), 32'h0);
        check("rr_rdata0", m0_rdata, 32'h0);
        check("rr_addr", s_addr, 32'h0);
        tick();
        g_resetn = 1; s_recv = 0;
        m0_req = 1; m1_req = 1; m1_addr = 32'h600;
        tick();
        check("rr_addr_win", s_addr, 32'h500);
        s_gnt = 1; #1;
        check("rr_gnt0", 32'(m0_gnt), 32'h1);
        check("rr_gnt1", 32'(m1_gnt), 32'h0);
        tick();
        s_gnt = 0; m0_req = 0; m1_req = 0;
        s_recv = 1; m0_ack = 1;
        tick();
        s_recv = 0; m0_ack = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL sim_timeout: bench did not complete");
        $fatal(1);
    end

endmodule
